// File: rtl/instruction_fetch.sv
// Fetch stage: issues in-order imem requests from pc, tracks in-flight PCs,
// buffers returned words in a paired instr/PC FIFO and drops stale words after a flush.
module instruction_fetch #(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc,
   output logic        pc_en,
   input  logic        flush,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

   logic [CW-1:0] inflight_q, inflight_d;
   logic [CW-1:0] drop_q, drop_d;
   logic [CW-1:0] count_q, count_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW-1:0] aq_wr_ptr_q, aq_wr_ptr_d, aq_rd_ptr_q, aq_rd_ptr_d;
   logic [31:0]   instr_mem_q [DEPTH];
   logic [31:0]   instr_mem_d [DEPTH];
   logic [31:0]   pc_mem_q [DEPTH];
   logic [31:0]   pc_mem_d [DEPTH];
   logic [31:0]   aq_mem_q [DEPTH];
   logic [31:0]   aq_mem_d [DEPTH];

   logic req_fire, resp_ok, push, pop;
   logic [CW:0] credit_used;

   always_comb begin
      credit_used    = {1'b0, inflight_q} + {1'b0, count_q};
      imem_req_valid = !rst && !flush && (credit_used < DEPTH_W);
      imem_req_addr  = pc;
      req_fire       = imem_req_valid && imem_req_ready;
      pc_en          = !rst && (req_fire || flush);
      // A response with nothing in flight is a protocol error and is ignored.
      resp_ok        = imem_resp_valid && (inflight_q != '0);
      pop            = (count_q != '0) && if_ready;
      push           = 1'b0;

      inflight_d  = inflight_q;
      drop_d      = drop_q;
      count_d     = count_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      aq_wr_ptr_d = aq_wr_ptr_q;
      aq_rd_ptr_d = aq_rd_ptr_q;
      instr_mem_d = instr_mem_q;
      pc_mem_d    = pc_mem_q;
      aq_mem_d    = aq_mem_q;

      if (resp_ok) begin
         aq_rd_ptr_d = aq_rd_ptr_q + AW'(1);
      end
      if (req_fire) begin
         aq_mem_d[aq_wr_ptr_q] = pc;
         aq_wr_ptr_d           = aq_wr_ptr_q + AW'(1);
      end

      if (flush) begin
         // Everything still outstanding becomes stale; the address queue is kept
         // so those stale responses keep it aligned as they drain.
         inflight_d = inflight_q - CW'(resp_ok);
         drop_d     = inflight_q - CW'(resp_ok);
         count_d    = '0;
         rd_ptr_d   = wr_ptr_q;
      end else begin
         push       = resp_ok && (drop_q == '0);
         inflight_d = inflight_q + CW'(req_fire) - CW'(resp_ok);
         if (resp_ok && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
         end
         if (push) begin
            instr_mem_d[wr_ptr_q] = imem_resp_data;
            pc_mem_d[wr_ptr_q]    = aq_mem_q[aq_rd_ptr_q];
            wr_ptr_d              = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         count_d = count_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         inflight_q  <= '0;
         drop_q      <= '0;
         count_q     <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         aq_wr_ptr_q <= '0;
         aq_rd_ptr_q <= '0;
         instr_mem_q <= '{default: '0};
         pc_mem_q    <= '{default: '0};
         aq_mem_q    <= '{default: '0};
      end else begin
         inflight_q  <= inflight_d;
         drop_q      <= drop_d;
         count_q     <= count_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         aq_wr_ptr_q <= aq_wr_ptr_d;
         aq_rd_ptr_q <= aq_rd_ptr_d;
         instr_mem_q <= instr_mem_d;
         pc_mem_q    <= pc_mem_d;
         aq_mem_q    <= aq_mem_d;
      end
   end

   always_comb begin
      if_valid = (count_q != '0);
      if_instr = instr_mem_q[rd_ptr_q];
      if_pc    = pc_mem_q[rd_ptr_q];
   end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a PC model and a 1..3-cycle
// in-order memory model whose data word is address + 0x1000_0000.
module tb_instruction_fetch;

   logic        clk;
   logic        rst;
   logic [31:0] pc;
   logic        pc_en;
   logic        flush;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;

   logic [31:0] target;
   int          lat;
   int          fire_cnt;
   int          n_checks;
   int          n_fail;
   int          n_wait;
   logic [2:0]  st_v;
   logic [31:0] st_a [3];

   instruction_fetch #(.DEPTH(4)) dut (
      .clk             (clk),
      .rst             (rst),
      .pc              (pc),
      .pc_en           (pc_en),
      .flush           (flush),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_req_addr   (imem_req_addr),
      .imem_resp_valid (imem_resp_valid),
      .imem_resp_data  (imem_resp_data),
      .if_valid        (if_valid),
      .if_ready        (if_ready),
      .if_instr        (if_instr),
      .if_pc           (if_pc)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // program_counter stand-in
   always @(posedge clk or posedge rst) begin
      if (rst) pc <= '0;
      else if (pc_en) pc <= flush ? target : pc + 32'd4;
   end

   // In-order memory: accepted request enters stage lat-1 and answers from stage 0.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         st_v     <= '0;
         fire_cnt <= 0;
      end else begin
         st_v[0] <= st_v[1];
         st_a[0] <= st_a[1];
         st_v[1] <= st_v[2];
         st_a[1] <= st_a[2];
         st_v[2] <= 1'b0;
         if (imem_req_valid && imem_req_ready) begin
            st_v[lat-1] <= 1'b1;
            st_a[lat-1] <= imem_req_addr;
            fire_cnt    <= fire_cnt + 1;
         end
      end
   end

   assign imem_resp_valid = st_v[0];
   assign imem_resp_data  = st_a[0] + 32'h1000_0000;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1; flush = 1'b0; target = '0; if_ready = 1'b1; imem_req_ready = 1'b1; lat = 1;
      repeat (2) @(negedge clk);

      check_eq("rst_if_valid", 32'(if_valid), 0);
      check_eq("rst_if_instr", if_instr, 0);
      check_eq("rst_if_pc", if_pc, 0);
      check_eq("rst_req_valid", 32'(imem_req_valid), 0);
      check_eq("rst_pc_en", 32'(pc_en), 0);

      // streaming, 1-cycle memory
      rst = 1'b0;
      #1;
      check_eq("first_req_valid", 32'(imem_req_valid), 1);
      check_eq("first_req_addr", imem_req_addr, 0);
      check_eq("first_pc_en", 32'(pc_en), 1);
      @(negedge clk);
      check_eq("no_bypass", 32'(if_valid), 0);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check_eq("stream_valid", 32'(if_valid), 1);
         check_eq("stream_pc", if_pc, 32'(4 * k));
         check_eq("stream_instr", if_instr, 32'h1000_0000 + 32'(4 * k));
         check_eq("stream_pc_en", 32'(pc_en), 1);
      end

      // asynchronous reset between edges
      #2;
      rst = 1'b1;
      if_ready = 1'b0;
      #1;
      check_eq("arst_if_valid", 32'(if_valid), 0);
      check_eq("arst_count", 32'(dut.count_q), 0);
      check_eq("arst_inflight", 32'(dut.inflight_q), 0);
      check_eq("arst_req_valid", 32'(imem_req_valid), 0);
      check_eq("arst_pc_en", 32'(pc_en), 0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check_eq("arst_first_addr", imem_req_addr, 0);
      check_eq("arst_first_valid", 32'(imem_req_valid), 1);

      // back-pressure: only DEPTH requests may be outstanding or buffered
      @(negedge clk);
      repeat (9) @(negedge clk);
      check_eq("bp_fires", 32'(fire_cnt), 4);
      check_eq("bp_req_valid", 32'(imem_req_valid), 0);
      check_eq("bp_pc_en", 32'(pc_en), 0);
      check_eq("bp_if_valid", 32'(if_valid), 1);
      check_eq("bp_hold_pc", if_pc, 0);
      check_eq("bp_hold_instr", if_instr, 32'h1000_0000);
      @(negedge clk);
      check_eq("bp_still_pc", if_pc, 0);
      if_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         #1;
         check_eq("bp_drain_valid", 32'(if_valid), 1);
         check_eq("bp_drain_pc", if_pc, 32'(4 * k));
         @(negedge clk);
      end

      // memory stall holds the PC
      rst = 1'b1;
      #1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_eq("stall_pc_start", pc, 32'h4);
      imem_req_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         check_eq("stall_pc_en", 32'(pc_en), 0);
         check_eq("stall_pc_held", pc, 32'h4);
         @(negedge clk);
      end
      imem_req_ready = 1'b1;
      #1;
      check_eq("stall_resume_addr", imem_req_addr, 32'h4);
      check_eq("stall_resume_pc_en", 32'(pc_en), 1);

      // flush with two stale requests, 3-cycle memory
      @(negedge clk);
      rst = 1'b1;
      lat = 3;
      #1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_eq("fl_inflight", 32'(dut.inflight_q), 2);
      flush  = 1'b1;
      target = 32'h100;
      #1;
      check_eq("fl_pc_en", 32'(pc_en), 1);
      check_eq("fl_req_valid", 32'(imem_req_valid), 0);
      @(negedge clk);
      flush = 1'b0;
      #1;
      check_eq("fl_if_valid_after", 32'(if_valid), 0);
      check_eq("fl_drop", 32'(dut.drop_q), 2);
      check_eq("fl_new_req_valid", 32'(imem_req_valid), 1);
      check_eq("fl_new_req_addr", imem_req_addr, 32'h100);
      n_wait = 0;
      while (!if_valid && n_wait < 20) begin
         @(negedge clk);
         n_wait++;
      end
      check_eq("fl_first_valid", 32'(if_valid), 1);
      check_eq("fl_first_pc", if_pc, 32'h100);
      check_eq("fl_first_instr", if_instr, 32'h1000_0100);

      // flush coinciding with a response and a decode pop, 2-cycle memory
      @(negedge clk);
      rst = 1'b1;
      lat = 2;
      #1;
      @(negedge clk);
      rst = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("fr_pre_valid", 32'(if_valid), 1);
      check_eq("fr_pre_pc", if_pc, 0);
      check_eq("fr_pre_resp", 32'(imem_resp_valid), 1);
      flush  = 1'b1;
      target = 32'h200;
      @(negedge clk);
      flush = 1'b0;
      check_eq("fr_count", 32'(dut.count_q), 0);
      check_eq("fr_drop", 32'(dut.drop_q), 1);
      check_eq("fr_inflight", 32'(dut.inflight_q), 1);
      check_eq("fr_if_valid", 32'(if_valid), 0);
      n_wait = 0;
      while (!if_valid && n_wait < 20) begin
         @(negedge clk);
         n_wait++;
      end
      check_eq("fr_first_valid", 32'(if_valid), 1);
      check_eq("fr_first_pc", if_pc, 32'h200);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage directly downstream of `program_counter`. It turns the current `pc` into in-order requests to instruction memory and tracks the PC of every in-flight request. Returned words are buffered in a small FIFO and presented to decode with a valid/ready handshake. It drives the PC's `en` so the PC advances only when a request is accepted or a redirect is taken, and it discards stale responses after a flush.

## Interface
- `DEPTH`, 4: buffer entries (power of two, ≥2); bounds in-flight requests plus buffered words.
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pc`  in  32  current PC from `program_counter`.
- `pc_en`  out  1  advance strobe to `program_counter` `en`.
- `flush`  in  1  redirect taken this cycle (branch mux not sequential).
- `imem_req_valid`  out  1  request valid.
- `imem_req_ready`  in  1  memory accepts request.
- `imem_req_addr`  out  32  request word address, equals `pc`.
- `imem_resp_valid`  in  1  response word valid (in order, ≥1 cycle after acceptance).
- `imem_resp_data`  in  32  response instruction.
- `if_valid`  out  1  instruction available to decode.
- `if_ready`  in  1  decode consumes instruction.
- `if_instr`  out  32  instruction at FIFO head.
- `if_pc`  out  32  PC of `if_instr`.

## Operation
- State: `inflight` counter (0..DEPTH), `drop` counter (0..DEPTH), `count` (0..DEPTH), paired instr/PC FIFO of DEPTH entries, and an address queue holding the PC of each in-flight request.
- Credit rule: `imem_req_valid = !flush && (inflight + count) < DEPTH`. It uses registered counts only and never depends on `if_ready`.
- Request fire (`imem_req_valid && imem_req_ready`): push `pc` to the address queue; `inflight` +1.
- `pc_en = req_fire | flush`. On flush the PC loads the redirect target and no request is issued.
- Response with `drop > 0`: discard the word, pop the address queue, `drop` −1, `inflight` −1.
- Response with `drop == 0` and `inflight > 0`: push {data, queued PC} into the FIFO, pop the address queue, `inflight` −1.
- Response with `inflight == 0`: protocol error. Ignore it and change no state.
- Decode pop: `if_valid && if_ready` pops the FIFO head.
- Flush cycle:
  - FIFO emptied (`count` ← 0); any same-cycle pop is irrelevant.
  - A same-cycle response is discarded.
  - `drop` ← `inflight − resp_valid`; `inflight` ← the same value.
  - The address queue keeps its entries, because stale responses still pop them.
- Flush while `drop > 0`: same rule, since `inflight` already includes stale entries.
- Counter arithmetic is unsigned with width clog2(DEPTH)+1. Pointers wrap modulo DEPTH. Overflow is impossible under the credit rule.

## Timing
- Reset (async, immediate): `inflight`, `drop`, `count`, and all pointers = 0.
  - Outputs during and after reset: `if_valid`=0, `if_instr`=0, `if_pc`=0.
  - `imem_req_valid` and `pc_en` are forced 0 while `rst` is high.
- First request: `imem_req_valid`=1 in the first cycle after `rst` deasserts. `imem_req_addr`=`pc` combinationally.
- Response latency: a response accepted at edge t gives `if_valid`=1 after edge t (registered FIFO, no bypass).
- Throughput: with 1-cycle memory and DEPTH≥3, one instruction per cycle is sustained while `if_ready`=1.
- Back-pressure: with `if_ready`=0, requests stop once `inflight + count == DEPTH`.
- Outputs during back-pressure: `if_instr`/`if_pc` hold stable while `if_valid && !if_ready`.
- After flush: `if_valid`=0 the following cycle. The new-target request issues the cycle after the flush, provided credits allow.
- Mid-operation reset: all in-flight and buffered work is abandoned. The memory model is reset with the same `rst`.

## Test plan
- Streaming: 1-cycle memory, `if_ready`=1, pc from 0x0 → `if_pc` sequence 0x0, 0x4, 0x8, … with one instruction per cycle; `pc_en` high every cycle from cycle 1.
- Back-pressure: `if_ready`=0 for 10 cycles → exactly 4 requests accepted. Then `imem_req_valid`=0 and `if_instr`/`if_pc` hold the 0x0 word. Release → words 0x0, 0x4, 0x8, 0xC appear in order with no loss.
- Flush with stale responses: 3-cycle memory, 2 requests in flight, `flush` with redirect to 0x100 → both old responses dropped. The first `if_valid` shows `if_pc`=0x100. `pc_en`=1 on the flush cycle.
- Flush coinciding with a response and a decode pop: that response is dropped, `count`=0 next cycle, and `drop` equals the remaining in-flight requests.
- Memory stall: `imem_req_ready`=0 for 5 cycles → `pc_en`=0 throughout and `pc` is held. The first accepted address equals the held `pc`.
- Async reset asserted mid-stream between clock edges → `if_valid`, `inflight`, `count` = 0 immediately. After deassertion, the first request uses `pc`=0x0.
